dot_map_writer: RTL and testbench
=================================

// Module: dot_map_writer
// PURPOSE
//  Owns the maze dot bitmap: ROWS x COLS bits, bit=1 means the dot is eaten, bit=0 means present.
//  Serves as the writer side of the per-row eaten-dot counters.
//  - Accepts eat requests from the player-movement logic.
//  - Sets the addressed bit and reports whether a dot was actually consumed.
//  - Keeps a running remaining-dot count.
//  - Exposes one registered row read port for the per-row counters and the renderer.
// PARAMETERS
//  ROWS   12                          number of maze rows
//  COLS   12                          bits per row (row word width)
//  ROW_W  $clog2(ROWS)                row address width
//  COL_W  $clog2(COLS)                column address width
//  CNT_W  $clog2(ROWS*COLS+1)         remaining-count width
// PORTS
//  Clk           in   1      system clock; all logic is on the rising edge
//  Reset         in   1      synchronous, active-high reset
//  start_level   in   1      1-cycle pulse: re-initialise the map (all dots present)
//  eat_valid     in   1      eat request valid
//  eat_ready     out  1      block can accept an eat request this cycle
//  eat_row       in   ROW_W  request row
//  eat_col       in   COL_W  request column
//  eat_done      out  1      1-cycle pulse: the accepted request has completed
//  eat_hit       out  1      valid with eat_done: 1 = a dot was present and is now eaten
//  pellet_hit    out  1      valid with eat_done: the eaten cell was a power pellet (see CONFIGURATION)
//  rd_row        in   ROW_W  read row select
//  rd_data       out  COLS   row word, 1-cycle latency; bit i = column i
//  remaining     out  CNT_W  dots not yet eaten
//  level_clear   out  1      registered flag: remaining==0 and state IDLE
//  busy          out  1      1 while in state INIT
// BEHAVIOUR
//  Reset values: state=INIT, init row counter=0, eat_ready=0, eat_done=0, eat_hit=0,
//    pellet_hit=0, rd_data=0, remaining=ROWS*COLS, level_clear=0, busy=1.
//  FSM states: INIT, IDLE, UPDATE.
//   INIT   - writes 0 to one row per cycle, rows 0..ROWS-1, so it lasts exactly ROWS cycles.
//            Moves to IDLE after row ROWS-1 is written. eat_ready=0.
//   IDLE   - eat_ready=1. A handshake is eat_valid & eat_ready at edge N:
//            the block latches row/col and moves to UPDATE.
//   UPDATE - one cycle. At edge N+1 the block:
//            - performs read-modify-write of the bit;
//            - decrements remaining only if the bit was 0;
//            - registers eat_done=1 and eat_hit=(old bit==0).
//            The block returns to IDLE, so eat_done is high for the cycle after edge N+1.
//            eat_ready=0 in UPDATE, so maximum throughput is 1 request per 2 cycles.
//  Out-of-range requests (eat_row>=ROWS or eat_col>=COLS) are accepted.
//    They produce eat_done=1 with eat_hit=0 and change no state.
//  Eating an already-eaten cell gives eat_hit=0; remaining is unchanged. remaining never underflows.
//  start_level pulse: has priority in every state and acts at the next edge.
//    - Enters INIT with the row counter at 0 and remaining=ROWS*COLS.
//    - Any request being processed in UPDATE is dropped with no eat_done.
//    - start_level during INIT restarts the walk from row 0.
//    - Reset has priority over start_level.
//  Read port:
//    - rd_data <= map[rd_row] each edge, in every state; rd_data = 0 if rd_row>=ROWS.
//    - A read and an UPDATE write to the same row at the same edge returns the old word (read-before-write).
//  level_clear is registered: it equals (remaining==0 && state==IDLE), delayed one cycle.
// CONFIGURATION
//  POWER_PELLET_EN defined:
//    - Cells (0,0), (0,COLS-1), (ROWS-1,0) and (ROWS-1,COLS-1) are power pellets.
//    - pellet_hit = eat_hit & (cell is a pellet), aligned with eat_done.
//    - Pellets count in remaining like ordinary dots.
//  POWER_PELLET_EN undefined: pellet_hit is tied to 0; all other behaviour is identical.
// TESTING
//  1 Reset 1 cycle -> busy=1 for exactly 12 cycles, then eat_ready=1;
//    remaining=144; rd_data=12'h000 for rows 0..11.
//  2 Eat (3,5) -> eat_done with eat_hit=1; remaining=143; rd_row=3 reads 12'h020 next cycle.
//  3 Eat (3,5) again -> eat_done with eat_hit=0; remaining stays 143.
//  4 Eat (12,0) and then (0,12) -> each gives eat_done with eat_hit=0; no map or count change.
//  5 Eat all 144 cells back-to-back -> remaining=0 and level_clear=1;
//    then start_level -> level_clear=0, remaining=144, busy for 12 cycles.
//  6 start_level in the UPDATE cycle of eat (0,1) -> no eat_done;
//    row 0 reads 12'h000 after INIT.
//    With POWER_PELLET_EN, eat (11,11) -> pellet_hit=1; eat (5,5) -> pellet_hit=0.

Source files
------------

// File: rtl/dot_map_writer.sv
// Maze dot bitmap owner: accepts eat requests, tracks remaining dots, serves a registered row read.
// Optional feature macro POWER_PELLET_EN: flags eats of the four corner cells on pellet_hit.
module dot_map_writer #(
    parameter int unsigned ROWS  = 12,
    parameter int unsigned COLS  = 12,
    parameter int unsigned ROW_W = $clog2(ROWS),
    parameter int unsigned COL_W = $clog2(COLS),
    parameter int unsigned CNT_W = $clog2(ROWS * COLS + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start_level,
    input  logic             eat_valid,
    output logic             eat_ready,
    input  logic [ROW_W-1:0] eat_row,
    input  logic [COL_W-1:0] eat_col,
    output logic             eat_done,
    output logic             eat_hit,
    output logic             pellet_hit,
    input  logic [ROW_W-1:0] rd_row,
    output logic [COLS-1:0]  rd_data,
    output logic [CNT_W-1:0] remaining,
    output logic             level_clear,
    output logic             busy
);

    typedef enum logic [1:0] {StInit, StIdle, StUpdate} state_e;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(ROWS * COLS);

    state_e           state;
    logic [ROW_W-1:0] init_row;
    logic [ROW_W-1:0] req_row;
    logic [COL_W-1:0] req_col;
    logic [COLS-1:0]  map [ROWS];

    logic req_in_range;
    logic rd_in_range;
    logic old_bit;
    logic hit;

    always_comb begin
        req_in_range = ({1'b0, req_row} < (ROW_W + 1)'(ROWS)) &&
                       ({1'b0, req_col} < (COL_W + 1)'(COLS));
        rd_in_range  = {1'b0, rd_row} < (ROW_W + 1)'(ROWS);
        // Out-of-range cells read as already eaten so they can never count as a hit.
        old_bit = 1'b1;
        if (req_in_range) begin
            old_bit = map[req_row][req_col];
        end
        hit = req_in_range && !old_bit;
    end

    assign eat_ready = (state == StIdle);
    assign busy      = (state == StInit);

`ifdef POWER_PELLET_EN
    logic req_pellet;
    assign req_pellet = (req_row == '0 || req_row == LAST_ROW) &&
                        (req_col == '0 || req_col == COL_W'(COLS - 1));
`else
    assign pellet_hit = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= StInit;
            init_row    <= '0;
            req_row     <= '0;
            req_col     <= '0;
            eat_done    <= 1'b0;
            eat_hit     <= 1'b0;
            rd_data     <= '0;
            remaining   <= TOTAL;
            level_clear <= 1'b0;
`ifdef POWER_PELLET_EN
            pellet_hit  <= 1'b0;
`endif
        end else begin
            // Read port samples the pre-write map, giving read-before-write on collisions.
            rd_data     <= rd_in_range ? map[rd_row] : '0;
            level_clear <= (remaining == '0) && (state == StIdle);
            eat_done    <= 1'b0;
            eat_hit     <= 1'b0;
`ifdef POWER_PELLET_EN
            pellet_hit  <= 1'b0;
`endif
            if (start_level) begin
                state     <= StInit;
                init_row  <= '0;
                remaining <= TOTAL;
            end else begin
                unique case (state)
                    StInit: begin
                        map[init_row] <= '0;
                        if (init_row == LAST_ROW) begin
                            state <= StIdle;
                        end else begin
                            init_row <= init_row + 1'b1;
                        end
                    end
                    StIdle: begin
                        if (eat_valid) begin
                            req_row <= eat_row;
                            req_col <= eat_col;
                            state   <= StUpdate;
                        end
                    end
                    StUpdate: begin
                        if (hit) begin
                            map[req_row][req_col] <= 1'b1;
                            if (remaining != '0) begin
                                remaining <= remaining - 1'b1;
                            end
                        end
                        eat_done <= 1'b1;
                        eat_hit  <= hit;
`ifdef POWER_PELLET_EN
                        pellet_hit <= hit && req_pellet;
`endif
                        state <= StIdle;
                    end
                    default: state <= StInit;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dot_map_writer.sv
// Directed bench for dot_map_writer: init walk, eat hits/misses, full clear, level restart.
module tb_dot_map_writer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start_level;
    logic        eat_valid;
    logic        eat_ready;
    logic [3:0]  eat_row;
    logic [3:0]  eat_col;
    logic        eat_done;
    logic        eat_hit;
    logic        pellet_hit;
    logic [3:0]  rd_row;
    logic [11:0] rd_data;
    logic [7:0]  remaining;
    logic        level_clear;
    logic        busy;

    int checks = 0;
    int errors = 0;

    dot_map_writer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .start_level (start_level),
        .eat_valid   (eat_valid),
        .eat_ready   (eat_ready),
        .eat_row     (eat_row),
        .eat_col     (eat_col),
        .eat_done    (eat_done),
        .eat_hit     (eat_hit),
        .pellet_hit  (pellet_hit),
        .rd_row      (rd_row),
        .rd_data     (rd_data),
        .remaining   (remaining),
        .level_clear (level_clear),
        .busy        (busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One handshake from IDLE; returns what was seen with eat_done (bounded wait).
    task automatic eat(input int r, input int c, output bit done, output bit hit,
                       output bit pel);
        eat_valid = 1'b1;
        eat_row   = 4'(r);
        eat_col   = 4'(c);
        tick();
        eat_valid = 1'b0;
        done = 1'b0;
        hit  = 1'b0;
        pel  = 1'b0;
        for (int n = 0; n < 4 && !done; n++) begin
            tick();
            if (eat_done) begin
                done = 1'b1;
                hit  = eat_hit;
                pel  = pellet_hit;
            end
        end
    endtask

    function automatic int count_busy_placeholder();
        return 0;
    endfunction

    initial begin
        bit done, hit, pel;
        int cnt;
        int hits;

        Reset       = 1'b1;
        start_level = 1'b0;
        eat_valid   = 1'b0;
        eat_row     = '0;
        eat_col     = '0;
        rd_row      = '0;
        tick();
        Reset = 1'b0;

        // 1: reset state and init walk
        check("rst_busy", busy, 1);
        check("rst_ready", eat_ready, 0);
        check("rst_remaining", remaining, 144);
        check("rst_done", eat_done, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_level_clear", level_clear, 0);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            tick();
        end
        check("init_busy_cycles", cnt, 12);
        check("init_ready", eat_ready, 1);
        for (int r = 0; r < 13; r++) begin
            rd_row = 4'(r);
            tick();
            check($sformatf("init_row%0d", r), rd_data, 0);
        end

        // 2: first eat hits
        eat(3, 5, done, hit, pel);
        check("eat35_done", done, 1);
        check("eat35_hit", hit, 1);
        check("eat35_remaining", remaining, 143);
        rd_row = 4'd3;
        tick();
        check("eat35_row3", rd_data, 12'h020);

        // 3: repeat is a miss
        eat(3, 5, done, hit, pel);
        check("reeat35_done", done, 1);
        check("reeat35_hit", hit, 0);
        check("reeat35_remaining", remaining, 143);

        // 4: out-of-range requests
        eat(12, 0, done, hit, pel);
        check("oor_row_done", done, 1);
        check("oor_row_hit", hit, 0);
        eat(0, 12, done, hit, pel);
        check("oor_col_done", done, 1);
        check("oor_col_hit", hit, 0);
        check("oor_remaining", remaining, 143);
        rd_row = 4'd0;
        tick();
        check("oor_row0", rd_data, 0);

        // read-before-write on the updated row
        rd_row = 4'd7;
        eat(7, 2, done, hit, pel);
        check("rbw_hit", hit, 1);
        check("rbw_old_word", rd_data, 0);
        tick();
        check("rbw_new_word", rd_data, 12'h004);

        // 5: eat every cell; (3,5) and (7,2) were already eaten
        hits = 0;
        for (int r = 0; r < 12; r++) begin
            for (int c = 0; c < 12; c++) begin
                eat(r, c, done, hit, pel);
                if (hit) hits++;
            end
        end
        check("all_hits", hits, 142);
        check("all_remaining", remaining, 0);
        rd_row = 4'd11;
        tick();
        check("all_level_clear", level_clear, 1);
        check("all_row11", rd_data, 12'hfff);

        start_level = 1'b1;
        tick();
        start_level = 1'b0;
        check("restart_remaining", remaining, 144);
        check("restart_busy", busy, 1);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            tick();
        end
        check("restart_busy_cycles", cnt, 12);
        check("restart_level_clear", level_clear, 0);
        rd_row = 4'd3;
        tick();
        check("restart_row3", rd_data, 0);

        // 6: start_level during UPDATE drops the request
        eat_valid = 1'b1;
        eat_row   = 4'd0;
        eat_col   = 4'd1;
        tick();
        eat_valid = 1'b0;
        check("upd_ready", eat_ready, 0);
        start_level = 1'b1;
        tick();
        start_level = 1'b0;
        hits = 0;
        cnt  = 0;
        while (busy && cnt < 100) begin
            if (eat_done) hits++;
            cnt++;
            tick();
        end
        check("drop_no_done", hits + 32'(eat_done), 0);
        check("drop_busy_cycles", cnt, 12);
        check("drop_remaining", remaining, 144);
        rd_row = 4'd0;
        tick();
        check("drop_row0", rd_data, 0);

        // pellets
        eat(11, 11, done, hit, pel);
        check("pel_corner_hit", hit, 1);
`ifdef POWER_PELLET_EN
        check("pel_corner", pel, 1);
`else
        check("pel_corner", pel, 0);
`endif
        eat(5, 5, done, hit, pel);
        check("pel_middle_hit", hit, 1);
        check("pel_middle", pel, 0);
        check("pel_remaining", remaining, 142);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
